// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - decode/issue sequencer driving ALU and Branch_control
// Accepts one RV32 instruction, issues a single ALU or branch-compare op, returns the result.
module alu_issue_ctrl #(
    parameter int SIZE = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [SIZE-1:0] in_pc,
    input  logic [SIZE-1:0] in_rs1,
    input  logic [SIZE-1:0] in_rs2,
    output logic            alu_en,
    output logic [3:0]      alu_sel,
    output logic [SIZE-1:0] alu_a,
    output logic [SIZE-1:0] alu_b,
    input  logic [SIZE-1:0] alu_y,
    output logic            br_en,
    output logic [2:0]      br_sel,
    output logic [SIZE-1:0] br_a,
    output logic [SIZE-1:0] br_b,
    input  logic            br_y,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_we,
    output logic [4:0]      out_rd,
    output logic [SIZE-1:0] out_data,
    output logic            out_br,
    output logic            out_taken,
    output logic [SIZE-1:0] out_target,
    output logic            out_illegal
);
    typedef enum logic [1:0] {IDLE, DECODE, EXEC, RESP} state_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    state_t          state_q, state_d;
    logic [31:0]     instr_q;
    logic [SIZE-1:0] pc_q, rs1_q, rs2_q, target_q;
    logic            is_br_q;

    logic [6:0]      opcode, funct7;
    logic [2:0]      funct3;
    logic [SIZE-1:0] imm_i, imm_b;
    logic            dec_legal, dec_br;
    logic [3:0]      dec_alu_sel;
    logic [2:0]      dec_br_sel;
    logic [SIZE-1:0] dec_b;

    assign opcode = instr_q[6:0];
    assign funct3 = instr_q[14:12];
    assign funct7 = instr_q[31:25];
    assign imm_i  = {{(SIZE-12){instr_q[31]}}, instr_q[31:20]};
    assign imm_b  = {{(SIZE-13){instr_q[31]}}, instr_q[31], instr_q[7],
                     instr_q[30:25], instr_q[11:8], 1'b0};

    always_comb begin
        dec_legal   = 1'b0;
        dec_br      = 1'b0;
        dec_alu_sel = 4'd0;
        dec_br_sel  = 3'd0;
        dec_b       = rs2_q;
        case (opcode)
            OPC_OP: begin
                if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'b000:  begin dec_legal = 1'b1; dec_alu_sel = 4'd0; end
                        3'b111:  begin dec_legal = 1'b1; dec_alu_sel = 4'd2; end
                        3'b110:  begin dec_legal = 1'b1; dec_alu_sel = 4'd3; end
                        default: dec_legal = 1'b0;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    dec_legal   = 1'b1;
                    dec_alu_sel = 4'd1;
                end
            end
            OPC_OP_IMM: begin
                dec_b = imm_i;
                case (funct3)
                    3'b000:  begin dec_legal = 1'b1; dec_alu_sel = 4'd0; end
                    3'b111:  begin dec_legal = 1'b1; dec_alu_sel = 4'd2; end
                    3'b110:  begin dec_legal = 1'b1; dec_alu_sel = 4'd3; end
                    default: dec_legal = 1'b0;
                endcase
            end
            OPC_BRANCH: begin
                dec_br = 1'b1;
                // Signed compares (BLT/BGE) are not supported by Branch_control.
                case (funct3)
                    3'b000:  begin dec_legal = 1'b1; dec_br_sel = 3'd0; end
                    3'b001:  begin dec_legal = 1'b1; dec_br_sel = 3'd1; end
                    3'b110:  begin dec_legal = 1'b1; dec_br_sel = 3'd3; end
                    3'b111:  begin dec_legal = 1'b1; dec_br_sel = 3'd4; end
                    default: dec_legal = 1'b0;
                endcase
            end
            default: dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = DECODE;
            DECODE:  state_d = dec_legal ? EXEC : RESP;
            EXEC:    state_d = RESP;
            RESP:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == RESP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            instr_q     <= '0;
            pc_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            target_q    <= '0;
            is_br_q     <= 1'b0;
            alu_en      <= 1'b0;
            alu_sel     <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            br_en       <= 1'b0;
            br_sel      <= '0;
            br_a        <= '0;
            br_b        <= '0;
            out_we      <= 1'b0;
            out_rd      <= '0;
            out_data    <= '0;
            out_br      <= 1'b0;
            out_taken   <= 1'b0;
            out_target  <= '0;
            out_illegal <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (in_valid) begin
                    instr_q <= in_instr;
                    pc_q    <= in_pc;
                    rs1_q   <= in_rs1;
                    rs2_q   <= in_rs2;
                end
                DECODE: begin
                    is_br_q  <= dec_br;
                    target_q <= pc_q + imm_b;
                    if (!dec_legal) begin
                        out_illegal <= 1'b1;
                        out_we      <= 1'b0;
                        out_rd      <= '0;
                        out_data    <= '0;
                        out_br      <= 1'b0;
                        out_taken   <= 1'b0;
                        out_target  <= '0;
                    end else if (dec_br) begin
                        br_en  <= 1'b1;
                        br_sel <= dec_br_sel;
                        br_a   <= rs1_q;
                        br_b   <= rs2_q;
                    end else begin
                        alu_en  <= 1'b1;
                        alu_sel <= dec_alu_sel;
                        alu_a   <= rs1_q;
                        alu_b   <= dec_b;
                    end
                end
                EXEC: begin
                    // sel/operands are left untouched so the ALU sees stable inputs.
                    alu_en      <= 1'b0;
                    br_en       <= 1'b0;
                    out_illegal <= 1'b0;
                    out_br      <= is_br_q;
                    if (is_br_q) begin
                        out_we     <= 1'b0;
                        out_rd     <= '0;
                        out_data   <= '0;
                        out_taken  <= br_y;
                        out_target <= target_q;
                    end else begin
                        out_we     <= (instr_q[11:7] != 5'd0);
                        out_rd     <= instr_q[11:7];
                        out_data   <= alu_y;
                        out_taken  <= 1'b0;
                        out_target <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - randomized scoreboard bench for alu_issue_ctrl
module tb_alu_issue_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] in_instr, in_pc, in_rs1, in_rs2;
    logic        alu_en;
    logic [3:0]  alu_sel;
    logic [31:0] alu_a, alu_b, alu_y;
    logic        br_en;
    logic [2:0]  br_sel;
    logic [31:0] br_a, br_b;
    logic        br_y;
    logic        out_valid, out_ready, out_we, out_br, out_taken, out_illegal;
    logic [4:0]  out_rd;
    logic [31:0] out_data, out_target;

    alu_issue_ctrl #(.SIZE(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .alu_en(alu_en), .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
        .br_en(br_en), .br_sel(br_sel), .br_a(br_a), .br_b(br_b), .br_y(br_y),
        .out_valid(out_valid), .out_ready(out_ready), .out_we(out_we), .out_rd(out_rd),
        .out_data(out_data), .out_br(out_br), .out_taken(out_taken),
        .out_target(out_target), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    // Stand-ins for the ALU and Branch_control blocks.
    always_comb begin
        case (alu_sel)
            4'd0:    alu_y = alu_a + alu_b;
            4'd1:    alu_y = alu_a - alu_b;
            4'd2:    alu_y = alu_a & alu_b;
            4'd3:    alu_y = alu_a | alu_b;
            default: alu_y = 32'hDEAD_BEEF;
        endcase
        case (br_sel)
            3'd0:    br_y = (br_a == br_b);
            3'd1:    br_y = (br_a != br_b);
            3'd3:    br_y = (br_a < br_b);
            3'd4:    br_y = (br_a >= br_b);
            default: br_y = 1'b0;
        endcase
    end

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          illegal, we, br, taken;
        bit [4:0]    rd;
        bit [31:0]   data, target, opa, opb;
        bit [3:0]    asel;
        bit [2:0]    bsel;
        int          n_alu, n_br;
        int unsigned acc;
    } exp_t;

    exp_t q_sb[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        total++;
        bad++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    function automatic exp_t model(input bit [31:0] ins, input bit [31:0] pc,
                                   input bit [31:0] rs1, input bit [31:0] rs2);
        exp_t      e;
        bit [6:0]  opc = ins[6:0];
        bit [2:0]  f3  = ins[14:12];
        bit [6:0]  f7  = ins[31:25];
        bit [31:0] imm_i = {{20{ins[31]}}, ins[31:20]};
        bit [31:0] imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        e = '{default: '0};
        e.illegal = 1'b1;
        if (opc == 7'h33) begin
            e.opa = rs1; e.opb = rs2; e.illegal = 1'b0;
            if      (f7 == 7'h00 && f3 == 3'b000) begin e.asel = 0; e.data = rs1 + rs2; end
            else if (f7 == 7'h20 && f3 == 3'b000) begin e.asel = 1; e.data = rs1 - rs2; end
            else if (f7 == 7'h00 && f3 == 3'b111) begin e.asel = 2; e.data = rs1 & rs2; end
            else if (f7 == 7'h00 && f3 == 3'b110) begin e.asel = 3; e.data = rs1 | rs2; end
            else e.illegal = 1'b1;
        end else if (opc == 7'h13) begin
            e.opa = rs1; e.opb = imm_i; e.illegal = 1'b0;
            if      (f3 == 3'b000) begin e.asel = 0; e.data = rs1 + imm_i; end
            else if (f3 == 3'b111) begin e.asel = 2; e.data = rs1 & imm_i; end
            else if (f3 == 3'b110) begin e.asel = 3; e.data = rs1 | imm_i; end
            else e.illegal = 1'b1;
        end else if (opc == 7'h63) begin
            e.opa = rs1; e.opb = rs2; e.illegal = 1'b0; e.br = 1'b1;
            e.target = pc + imm_b;
            if      (f3 == 3'b000) begin e.bsel = 0; e.taken = (rs1 == rs2); end
            else if (f3 == 3'b001) begin e.bsel = 1; e.taken = (rs1 != rs2); end
            else if (f3 == 3'b110) begin e.bsel = 3; e.taken = (rs1 <  rs2); end
            else if (f3 == 3'b111) begin e.bsel = 4; e.taken = (rs1 >= rs2); end
            else begin e.illegal = 1'b1; e.br = 1'b0; end
        end
        if (e.illegal) begin
            e = '{default: '0};
            e.illegal = 1'b1;
        end else if (e.br) begin
            e.n_br = 1;
        end else begin
            e.n_alu = 1;
            e.rd    = ins[11:7];
            e.we    = (ins[11:7] != 5'd0);
        end
        return e;
    endfunction

    task automatic issue(input bit [31:0] ins, input bit [31:0] pc,
                         input bit [31:0] rs1, input bit [31:0] rs2, input bit push);
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1; in_instr = ins; in_pc = pc; in_rs1 = rs1; in_rs2 = rs2;
        for (int k = 0; k < 64 && !in_ready; k++) @(negedge clk);
        if (!in_ready) begin
            fail_now("in_ready_timeout");
            in_valid = 1'b0;
            return;
        end
        e = model(ins, pc, rs1, rs2);
        e.acc = cyc;
        if (push) q_sb.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
        in_instr = $urandom;
    endtask

    // Monitor: tracks enable pulses, pops the scoreboard on each new response.
    initial begin : monitor
        int        resp_cnt = 0;
        int        stall_left = 0;
        int        n_alu = 0, n_br = 0;
        bit        seen = 0;
        exp_t      e;
        logic [3:0]  o_asel = '0;
        logic [2:0]  o_bsel = '0;
        logic [31:0] o_aa = '0, o_ab = '0, o_ba = '0, o_bb = '0;
        logic [31:0] s_data = '0, s_tgt = '0;
        logic [4:0]  s_rd = '0;
        logic [3:0]  s_flags = '0;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                n_alu = 0; n_br = 0; seen = 0; out_ready = 1'b0;
                continue;
            end
            if (alu_en || br_en) begin
                chk("en_exclusive", 32'(alu_en && br_en), 32'd0);
                if (alu_en) begin n_alu++; o_asel = alu_sel; o_aa = alu_a; o_ab = alu_b; end
                if (br_en)  begin n_br++;  o_bsel = br_sel;  o_ba = br_a;  o_bb = br_b;  end
            end
            if (out_valid) begin
                chk("in_ready_busy", 32'(in_ready), 32'd0);
                if (!seen) begin
                    seen = 1;
                    if (q_sb.size() == 0) begin
                        fail_now("unexpected_response");
                    end else begin
                        e = q_sb.pop_front();
                        chk("illegal", 32'(out_illegal), 32'(e.illegal));
                        chk("we",      32'(out_we),      32'(e.we));
                        chk("br",      32'(out_br),      32'(e.br));
                        chk("taken",   32'(out_taken),   32'(e.taken));
                        chk("latency", cyc - e.acc,      e.illegal ? 32'd2 : 32'd3);
                        chk("alu_en_pulses", 32'(n_alu), 32'(e.n_alu));
                        chk("br_en_pulses",  32'(n_br),  32'(e.n_br));
                        if (!e.br) chk("data", out_data, e.data);
                        if (e.n_alu == 1) begin
                            chk("rd",      32'(out_rd),  32'(e.rd));
                            chk("alu_sel", 32'(o_asel),  32'(e.asel));
                            chk("alu_a",   o_aa,         e.opa);
                            chk("alu_b",   o_ab,         e.opb);
                        end
                        if (e.n_br == 1) begin
                            chk("target", out_target, e.target);
                            chk("br_sel", 32'(o_bsel), 32'(e.bsel));
                            chk("br_a",   o_ba,        e.opa);
                            chk("br_b",   o_bb,        e.opb);
                        end
                    end
                    s_data = out_data; s_tgt = out_target; s_rd = out_rd;
                    s_flags = {out_we, out_br, out_taken, out_illegal};
                    stall_left = (resp_cnt == 0) ? 5 : 0;
                    resp_cnt++;
                    n_alu = 0; n_br = 0;
                end else begin
                    chk("hold_data",   out_data,   s_data);
                    chk("hold_target", out_target, s_tgt);
                    chk("hold_rd",     32'(out_rd), 32'(s_rd));
                    chk("hold_flags",  32'({out_we, out_br, out_taken, out_illegal}), 32'(s_flags));
                end
                if (stall_left > 0) begin
                    out_ready = 1'b0;
                    stall_left--;
                end else begin
                    out_ready = 1'($urandom_range(0, 1));
                end
                if (out_ready) seen = 0;
            end else begin
                out_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin : stimulus
        bit [31:0] ins, rs1, rs2, pc;
        bit [2:0]  f3;
        bit [6:0]  f7;
        bit [4:0]  rd;
        int        kind;
        rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; in_rs1 = '0; in_rs2 = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_en",        32'({alu_en, br_en}), 32'd0);
        chk("rst_sels",      32'({alu_sel, br_sel}), 32'd0);
        chk("rst_ops",       alu_a | alu_b | br_a | br_b, 32'd0);
        chk("rst_outs",      out_data | out_target | 32'(out_rd) |
                             32'({out_we, out_br, out_taken, out_illegal}), 32'd0);
        rst = 1'b0;

        issue(32'h002081B3, 32'h0000_0000, 32'd5, 32'd7, 1'b1);
        issue(32'h402081B3, 32'h0000_0004, 32'd3, 32'd5, 1'b1);
        issue(32'hFFF00293, 32'h0000_0008, 32'd0, 32'd0, 1'b1);
        issue(32'h00208463, 32'h0000_0100, 32'd9, 32'd9, 1'b1);
        issue(32'h0000_0000, 32'h0000_0010, 32'd1, 32'd2, 1'b1);
        issue(32'h0020C463, 32'h0000_0200, 32'd1, 32'd2, 1'b1);

        // Abort a request in EXEC: nothing may come back from it.
        for (int k = 0; k < 200 && (q_sb.size() != 0 || out_valid); k++) @(negedge clk);
        issue(32'h002081B3, 32'h0, 32'd11, 32'd22, 1'b0);
        for (int k = 0; k < 10 && !alu_en; k++) @(negedge clk);
        if (!alu_en) fail_now("exec_not_reached");
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_in_ready",  32'(in_ready),  32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_en",        32'({alu_en, br_en}), 32'd0);
        chk("abort_sels",      32'({alu_sel, br_sel}), 32'd0);
        chk("abort_ops",       alu_a | alu_b | br_a | br_b, 32'd0);
        chk("abort_outs",      out_data | out_target | 32'(out_rd) |
                               32'({out_we, out_br, out_taken, out_illegal}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int n = 0; n < 150; n++) begin
            kind = $urandom_range(0, 9);
            rd   = 5'($urandom_range(0, 31));
            ins  = $urandom;
            case (kind)
                0, 1, 2: begin
                    f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000 | 3'($urandom_range(0, 1) * 6 + $urandom_range(0, 1));
                    f7 = ($urandom_range(0, 2) == 0) ? 7'h20 : 7'h00;
                    ins = {f7, ins[24:15], f3, rd, 7'h33};
                end
                3, 4, 5: begin
                    f3 = 3'($urandom);
                    ins = {ins[31:15], f3, rd, 7'h13};
                end
                6, 7, 8: begin
                    f3 = 3'($urandom);
                    ins = {ins[31:15], f3, ins[11:7], 7'h63};
                end
                default: ;
            endcase
            rs1 = $urandom;
            rs2 = ($urandom_range(0, 3) == 0) ? rs1 : $urandom;
            pc  = $urandom & 32'hFFFF_FFFC;
            issue(ins, pc, rs1, rs2, 1'b1);
        end

        for (int k = 0; k < 500 && (q_sb.size() != 0 || out_valid); k++) @(negedge clk);
        if (q_sb.size() != 0) fail_now("responses_missing");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
